// File: rtl/vga_rx_decoder.sv
// -----------------------------------------------------------------------------
// vga_rx_decoder
//
// Recovers pixel position and frame lock from an incoming VGA timing stream.
// The sync inputs are sampled every pixel clock.  An internal column/line
// counter is aligned on a vsync falling edge and then every hsync/vsync edge
// is compared against where the counter says it should be.  Any early, late,
// extra or missing edge is a mismatch.  A three-state lock machine
// (SEARCH -> TRACK -> LOCKED) decides whether the recovered position is
// trustworthy.
//
// Ports
//   CLK_25MH     in   1   pixel clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   hsync_in     in   1   active-low horizontal sync
//   vsync_in     in   1   active-low vertical sync
//   rgb_in       in   3   pixel colour
//   pix_x        out  10  column of the presented sample
//   pix_y        out  10  line of the presented sample
//   pix_rgb      out  3   colour of the presented sample
//   pix_valid    out  1   locked and sample inside the visible area
//   frame_start  out  1   one-cycle pulse at column 0, line 0 while locked
//   locked       out  1   lock machine is in LOCKED
//   lock_state   out  2   00 SEARCH, 01 TRACK, 10 LOCKED
//   sync_error   out  1   one-cycle pulse when lock is lost
//   frame_count  out  8   frames started while locked (wraps)
//
// Latency: a sample is registered on one edge and the outputs describing it
// are registered on the next edge.
// -----------------------------------------------------------------------------
module vga_rx_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492
) (
    input  logic       CLK_25MH,
    input  logic       reset_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [1:0] lock_state,
    output logic       sync_error,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_LAST_C       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE_C     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_C     = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START_C = 10'(H_SYNC_START);
    localparam logic [9:0] H_SYNC_END_C   = 10'(H_SYNC_END);
    localparam logic [9:0] V_SYNC_START_C = 10'(V_SYNC_START);
    localparam logic [9:0] V_SYNC_END_C   = 10'(V_SYNC_END);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t     state_r;
    state_t     next_state_s;

    logic       hs_r, vs_r, hs_prev_r, vs_prev_r;
    logic [2:0] rgb_r;
    logic [9:0] col_r, line_r;

    logic       hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
    logic [9:0] cur_col_s, cur_line_s;
    logic [9:0] col_nxt_s, line_nxt_s;
    logic       mismatch_s;
    logic       visible_s;
    logic       top_left_s;

    // Input sample register (sample N) and previous sample (N-1) for edges.
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            hs_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
            rgb_r     <= 3'b000;
        end else begin
            hs_prev_r <= hs_r;
            vs_prev_r <= vs_r;
            hs_r      <= hsync_in;
            vs_r      <= vsync_in;
            rgb_r     <= rgb_in;
        end
    end

    assign hs_fall_s = hs_prev_r & ~hs_r;
    assign hs_rise_s = ~hs_prev_r & hs_r;
    assign vs_fall_s = vs_prev_r & ~vs_r;
    assign vs_rise_s = ~vs_prev_r & vs_r;

    // Position of the current sample; a vsync fall seen while searching
    // re-anchors this very sample to column 0 of the vsync start line.
    always_comb begin
        cur_col_s  = col_r;
        cur_line_s = line_r;
        if ((state_r == ST_SEARCH) && vs_fall_s) begin
            cur_col_s  = 10'd0;
            cur_line_s = V_SYNC_START_C;
        end else begin
            cur_col_s  = col_r;
            cur_line_s = line_r;
        end
    end

    // Counter advance for the following sample, wrapping col and line together.
    always_comb begin
        col_nxt_s  = cur_col_s + 10'd1;
        line_nxt_s = cur_line_s;
        if (cur_col_s == H_LAST_C) begin
            col_nxt_s = 10'd0;
            if (cur_line_s == V_LAST_C) begin
                line_nxt_s = 10'd0;
            end else begin
                line_nxt_s = cur_line_s + 10'd1;
            end
        end else begin
            col_nxt_s  = cur_col_s + 10'd1;
            line_nxt_s = cur_line_s;
        end
    end

    // Each edge is compared independently against its expected position, so
    // an edge that is absent where expected and one that appears elsewhere
    // both register, and simultaneous hsync/vsync edges are each checked.
    assign mismatch_s =
        (hs_fall_s ^ (cur_col_s == H_SYNC_START_C)) |
        (hs_rise_s ^ (cur_col_s == H_SYNC_END_C)) |
        (vs_fall_s ^ ((cur_col_s == 10'd0) && (cur_line_s == V_SYNC_START_C))) |
        (vs_rise_s ^ ((cur_col_s == 10'd0) && (cur_line_s == V_SYNC_END_C)));

    assign visible_s  = (cur_col_s < H_ACTIVE_C) && (cur_line_s < V_ACTIVE_C);
    assign top_left_s = (cur_col_s == 10'd0) && (cur_line_s == 10'd0);

    // Lock machine transition for the current sample.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (vs_fall_s) begin
                    next_state_s = ST_TRACK;
                end else begin
                    next_state_s = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (mismatch_s) begin
                    next_state_s = ST_SEARCH;
                end else if (vs_fall_s) begin
                    next_state_s = ST_LOCKED;
                end else begin
                    next_state_s = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (mismatch_s) begin
                    next_state_s = ST_SEARCH;
                end else begin
                    next_state_s = ST_LOCKED;
                end
            end
            default: begin
                next_state_s = ST_SEARCH;
            end
        endcase
    end

    // Column/line counter register.
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            col_r  <= 10'd0;
            line_r <= 10'd0;
        end else begin
            col_r  <= col_nxt_s;
            line_r <= line_nxt_s;
        end
    end

    // Lock state and all registered outputs describing the current sample.
    always_ff @(posedge CLK_25MH or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_SEARCH;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 3'b000;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            lock_state  <= 2'b00;
            sync_error  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            pix_x       <= cur_col_s;
            pix_y       <= cur_line_s;
            pix_rgb     <= rgb_r;
            pix_valid   <= (next_state_s == ST_LOCKED) && visible_s;
            frame_start <= (next_state_s == ST_LOCKED) && top_left_s;
            locked      <= (next_state_s == ST_LOCKED);
            lock_state  <= next_state_s;
            // Only losing an established lock is an error; TRACK failures are silent.
            sync_error  <= (state_r == ST_LOCKED) && mismatch_s;
            if ((next_state_s == ST_LOCKED) && top_left_s) begin
                frame_count <= frame_count + 8'd1;
            end else begin
                frame_count <= frame_count;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder.  The DUT is built with a shrunken raster
// (16x10 instead of 800x525) so that multi-frame and 256-frame scenarios stay
// short; all positions below are the scaled equivalents of the full-size ones.
module tb_vga_rx_decoder;

    localparam int HT  = 16;
    localparam int HA  = 10;
    localparam int HSS = 11;
    localparam int HSE = 14;
    localparam int VT  = 10;
    localparam int VA  = 6;
    localparam int VSS = 7;
    localparam int VSE = 9;
    localparam int BUDGET = 2 * HT * VT + 10;

    logic       CLK_25MH = 1'b0;
    logic       reset_n;
    logic       hsync_in, vsync_in;
    logic [2:0] rgb_in;
    logic [9:0] pix_x, pix_y;
    logic [2:0] pix_rgb;
    logic       pix_valid, frame_start, locked, sync_error;
    logic [1:0] lock_state;
    logic [7:0] frame_count;

    int compared   = 0;
    int mismatched = 0;

    // Source raster position of the next sample to drive.
    int src_col, src_line;
    bit delay_h, miss_v, err_seen;
    // Positions of the last two driven samples; outputs lag drive by two negedges.
    int h1_col, h1_line, h2_col, h2_line, o_col, o_line;

    always #20 CLK_25MH = ~CLK_25MH;

    vga_rx_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .CLK_25MH(CLK_25MH), .reset_n(reset_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .locked(locked), .lock_state(lock_state),
        .sync_error(sync_error), .frame_count(frame_count)
    );

    task automatic tick();
        logic hs, vs;
        @(negedge CLK_25MH);
        o_col   = h2_col;
        o_line  = h2_line;
        h2_col  = h1_col;
        h2_line = h1_line;
        if (sync_error) err_seen = 1'b1;
        hs = !(src_col >= HSS && src_col < HSE);
        if (delay_h && src_col == HSS) begin
            hs = 1'b1;
            delay_h = 1'b0;
        end
        vs = !(src_line >= VSS && src_line < VSE);
        if (miss_v) begin
            vs = 1'b1;
            if (src_col == 0 && src_line == VSE) miss_v = 1'b0;
        end
        hsync_in = hs;
        vsync_in = vs;
        if (src_col == 5 && src_line == 4) rgb_in = 3'b101;
        else rgb_in = 3'((src_col ^ src_line) & 7);
        h1_col  = src_col;
        h1_line = src_line;
        src_col = src_col + 1;
        if (src_col == HT) begin
            src_col  = 0;
            src_line = (src_line == VT - 1) ? 0 : src_line + 1;
        end
    endtask

    task automatic invalidate();
        h1_col = -1; h1_line = -1; h2_col = -1; h2_line = -1;
    endtask

    // Advance until the outputs describe sample (c,l); n returns ticks used.
    task automatic run_to(input int c, input int l, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(o_col == c && o_line == l) && n < BUDGET);
        if (!(o_col == c && o_line == l)) begin
            compared++;
            mismatched++;
            $display("FAIL run_to(%0d,%0d): position not reached within %0d cycles", c, l, BUDGET);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 3'b000;
        src_col = 5; src_line = 2; delay_h = 0; miss_v = 0; err_seen = 0;
        invalidate();
        repeat (3) tick();
        compared++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, lock_state,
             sync_error, frame_count} !== 38'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%b v=%b fs=%b lk=%b st=%b se=%b fc=%0d, want all 0",
                     pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, lock_state, sync_error, frame_count);
        end
        reset_n = 1'b1;
        invalidate();
    endtask

    task automatic test_lock();
        int n;
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b01 || locked !== 1'b0) begin
            mismatched++;
            $display("FAIL first_vfall_track: got state=%b locked=%b, want 01/0", lock_state, locked);
        end
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b10 || locked !== 1'b1) begin
            mismatched++;
            $display("FAIL second_vfall_lock: got state=%b locked=%b, want 10/1", lock_state, locked);
        end
        run_to(0, 0, n);
        compared++;
        if (n !== 48) begin
            mismatched++;
            $display("FAIL frame_start_delay: got %0d cycles, want 48", n);
        end
        compared++;
        if (frame_start !== 1'b1 || frame_count !== 8'd1) begin
            mismatched++;
            $display("FAIL first_frame_start: got fs=%b fc=%0d, want 1/1", frame_start, frame_count);
        end
        tick();
        compared++;
        if (frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_start_width: got %b, want 0", frame_start);
        end
    endtask

    task automatic test_pixel();
        int n;
        run_to(12, 3, n);
        compared++;
        if (pix_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL blank_col12: got valid=%b, want 0", pix_valid);
        end
        run_to(5, 4, n);
        compared++;
        if (pix_x !== 10'd5 || pix_y !== 10'd4 || pix_rgb !== 3'b101 || pix_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL pixel_5_4: got x=%0d y=%0d rgb=%b v=%b, want 5 4 101 1", pix_x, pix_y, pix_rgb, pix_valid);
        end
        run_to(9, 5, n);
        compared++;
        if (pix_rgb !== 3'b100 || pix_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL last_visible: got rgb=%b v=%b, want 100 1", pix_rgb, pix_valid);
        end
        run_to(10, 5, n);
        compared++;
        if (pix_valid !== 1'b0 || pix_x !== 10'd10) begin
            mismatched++;
            $display("FAIL col_boundary: got x=%0d v=%b, want 10 0", pix_x, pix_valid);
        end
        run_to(0, 6, n);
        compared++;
        if (pix_valid !== 1'b0 || pix_y !== 10'd6) begin
            mismatched++;
            $display("FAIL line_boundary: got y=%0d v=%b, want 6 0", pix_y, pix_valid);
        end
    endtask

    task automatic test_hsync_error();
        int n;
        run_to(0, 2, n);
        delay_h = 1'b1;
        run_to(HSS, 2, n);
        compared++;
        if (sync_error !== 1'b1 || locked !== 1'b0 || lock_state !== 2'b00) begin
            mismatched++;
            $display("FAIL late_hfall: got se=%b lk=%b st=%b, want 1 0 00", sync_error, locked, lock_state);
        end
        tick();
        compared++;
        if (sync_error !== 1'b0) begin
            mismatched++;
            $display("FAIL sync_error_width: got %b, want 0", sync_error);
        end
        err_seen = 1'b0;
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b01) begin
            mismatched++;
            $display("FAIL retrack: got state=%b, want 01", lock_state);
        end
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b10 || locked !== 1'b1 || err_seen !== 1'b0) begin
            mismatched++;
            $display("FAIL relock: got state=%b lk=%b err_seen=%b, want 10 1 0", lock_state, locked, err_seen);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        run_to(0, 3, n);
        #5 reset_n = 1'b0;
        #1;
        compared++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, lock_state,
             sync_error, frame_count} !== 38'd0) begin
            mismatched++;
            $display("FAIL async_reset: got x=%0d y=%0d v=%b lk=%b st=%b fc=%0d, want all 0",
                     pix_x, pix_y, pix_valid, locked, lock_state, frame_count);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        invalidate();
        err_seen = 1'b0;
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b01 || err_seen !== 1'b0 || frame_count !== 8'd0) begin
            mismatched++;
            $display("FAIL post_reset_track: got state=%b err_seen=%b fc=%0d, want 01 0 0",
                     lock_state, err_seen, frame_count);
        end
    endtask

    task automatic test_missing_vsync();
        int n;
        run_to(0, 2, n);
        miss_v = 1'b1;
        err_seen = 1'b0;
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b00 || sync_error !== 1'b0) begin
            mismatched++;
            $display("FAIL missing_vfall: got state=%b se=%b, want 00 0", lock_state, sync_error);
        end
        run_to(0, VSS, n);
        compared++;
        if (lock_state !== 2'b01 || err_seen !== 1'b0) begin
            mismatched++;
            $display("FAIL missing_vfall_quiet: got state=%b err_seen=%b, want 01 0", lock_state, err_seen);
        end
        run_to(0, VSS, n);
        compared++;
        if (locked !== 1'b1) begin
            mismatched++;
            $display("FAIL relock_after_miss: got locked=%b, want 1", locked);
        end
    endtask

    task automatic test_frame_wrap();
        int n;
        logic [7:0] exp_fc;
        for (int i = 0; i < 256; i++) begin
            run_to(0, 0, n);
            exp_fc = 8'((i + 1) & 255);
            compared++;
            if (frame_start !== 1'b1 || frame_count !== exp_fc) begin
                mismatched++;
                $display("FAIL frame_wrap[%0d]: got fs=%b fc=%0d, want 1 %0d", i, frame_start, frame_count, exp_fc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixel();
        test_hsync_error();
        test_reset_midframe();
        test_missing_vsync();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_rx_decoder.md
VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

Interface
REQ-001 Parameters: H_TOTAL, 800, pixels per line; H_ACTIVE, 640, visible columns; H_SYNC_START, 656, hsync low start column; H_SYNC_END, 752, hsync high return column.
REQ-002 Parameters: V_TOTAL, 525, lines per frame; V_ACTIVE, 480, visible lines; V_SYNC_START, 490, vsync low start line; V_SYNC_END, 492, vsync high return line.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 CLK_25MH  input  1  pixel clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 hsync_in, vsync_in  input  1 each  active-low syncs from the VGA timing source, same clock domain.
REQ-007 rgb_in  input  3  pixel colour from the VGA timing source.
REQ-008 pix_x, pix_y  output  10 each  recovered column and line of the presented sample.
REQ-009 pix_rgb  output  3  colour of the presented sample.
REQ-010 pix_valid  output  1  high when locked and sample is inside the visible area.
REQ-011 frame_start  output  1  one-cycle pulse at column 0, line 0 while locked.
REQ-012 locked  output  1  high in LOCKED state; lock_state  output  2  00 SEARCH, 01 TRACK, 10 LOCKED.
REQ-013 sync_error  output  1  one-cycle pulse on loss of lock; frame_count  output  8  frames seen while locked.

Function
REQ-014 Inputs SHALL be registered every cycle (sample N); edges SHALL be detected against the previous sample (N-1); all outputs SHALL be registered and reflect sample N one cycle later.
REQ-015 Internal col (0..799) and line (0..524) SHALL give the position of the current sample; col wraps 799->0 and increments line; line wraps 524->0 on the same cycle as col 799->0.
REQ-016 Expected edge positions: hsync fall at col 656; hsync rise at col 752; vsync fall at col 0, line 490; vsync rise at col 0, line 492.
REQ-017 Mismatch SHALL be flagged for any of the four edges when "edge observed" differs from "counter at expected position": early, late, extra and missing edges are all mismatches.
REQ-018 SEARCH: counters free-running, mismatches ignored; on a vsync fall, load col=0, line=490 for that sample and go to TRACK.
REQ-019 TRACK: a mismatch returns to SEARCH with no sync_error; the next vsync fall with no mismatch since entry goes to LOCKED.
REQ-020 LOCKED: a mismatch goes to SEARCH, pulses sync_error for exactly one cycle, deasserts locked on the same output cycle, and forces pix_valid low.
REQ-021 pix_valid = LOCKED && col < 640 && line < 480 for the presented sample; pix_x, pix_y and pix_rgb SHALL update every cycle regardless of state.
REQ-022 frame_start SHALL pulse when a LOCKED sample has col 0 and line 0; frame_count SHALL increment on that pulse and wrap 255->0.
REQ-023 A simultaneous hsync and vsync edge SHALL be checked independently; either mismatch counts.

Reset
REQ-024 While reset_n is low, all outputs SHALL be 0 immediately (asynchronously), including frame_count; lock_state SHALL be SEARCH and col, line and input registers SHALL clear.
REQ-025 Reset deassertion mid-frame SHALL restart in SEARCH; no sync_error or frame_start pulse SHALL be produced by reset itself.

Verification
REQ-026 Reset, then a clean 800x525 source: first vsync fall -> TRACK; second vsync fall -> locked=1; frame_start fires 35 lines later with frame_count=1.
REQ-027 Locked, source drives rgb_in=101 at col 100, line 200 -> one cycle later pix_x=100, pix_y=200, pix_rgb=101, pix_valid=1; at col 700 -> pix_valid=0.
REQ-028 Locked, one hsync fall delayed to col 657 -> single-cycle sync_error, locked=0, lock_state=00; relock after two further clean vsync falls.
REQ-029 TRACK, a missing vsync fall -> return to SEARCH with sync_error never asserted.
REQ-030 reset_n pulsed low at line 300 while locked -> all outputs 0 asynchronously; after release the normal relock sequence completes.
REQ-031 256 locked frames -> frame_count wraps from 255 to 0 on the 256th frame_start.
